// File: rtl/jtag_tap_controller_if.sv
// jtag_tap_controller_if: TAP serial pins, user-DR hooks and status outputs of the TAP controller.
interface jtag_tap_controller_if #(parameter int IR_WIDTH = 4);
  logic tms, tdi, tdo, tdo_en, ext_tdo, ext_sel, capture_dr, shift_dr, update_dr, tlr;
  logic [IR_WIDTH-1:0] ir_out;
  modport master (
    output tms, tdi, ext_tdo,
    input  tdo, tdo_en, ext_sel, capture_dr, shift_dr, update_dr, ir_out, tlr
  );
  modport slave (
    input  tms, tdi, ext_tdo,
    output tdo, tdo_en, ext_sel, capture_dr, shift_dr, update_dr, ir_out, tlr
  );
endinterface

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: IEEE 1149.1 TAP with BYPASS and USER_DR; define JTAG_IDCODE_EN to add the
// 32-bit ID register, the IDCODE opcode and IDCODE as the reset instruction.
module jtag_tap_controller #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input logic tck,
  input logic trst,
  jtag_tap_controller_if.slave bus
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_t;
  localparam logic [IR_WIDTH-1:0] OP_USER   = {1'b1, {(IR_WIDTH-1){1'b0}}};
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_RST    = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RST    = OP_BYPASS;
`endif
  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("IR_WIDTH must be at least 2");
  end
  if (!IDCODE_VALUE[0]) begin : g_bad_idcode
    $error("IDCODE_VALUE bit 0 must be 1");
  end
  state_t              state, nxt;
  logic [IR_WIDTH-1:0] ir, ir_shift, ir_nxt;
  logic                bypass, dr_src, tdo_src, shifting, user_nxt;
  always_comb begin
    nxt = TLR;
    unique case (state)
      TLR:                 nxt = bus.tms ? TLR    : RTI;
      RTI, UPD_DR, UPD_IR: nxt = bus.tms ? SEL_DR : RTI;
      SEL_DR:              nxt = bus.tms ? SEL_IR : CAP_DR;
      CAP_DR, SH_DR:       nxt = bus.tms ? EX1_DR : SH_DR;
      EX1_DR:              nxt = bus.tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR:            nxt = bus.tms ? EX2_DR : PAUSE_DR;
      EX2_DR:              nxt = bus.tms ? UPD_DR : SH_DR;
      SEL_IR:              nxt = bus.tms ? TLR    : CAP_IR;
      CAP_IR, SH_IR:       nxt = bus.tms ? EX1_IR : SH_IR;
      EX1_IR:              nxt = bus.tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR:            nxt = bus.tms ? EX2_IR : PAUSE_IR;
      EX2_IR:              nxt = bus.tms ? UPD_IR : SH_IR;
      default:             nxt = TLR;
    endcase
  end
  // The instruction only moves when leaving Update-IR, so a DR scan always sees a stable opcode.
  assign ir_nxt   = nxt == TLR ? IR_RST : state == UPD_IR ? ir_shift : ir;
  assign user_nxt = ir_nxt == OP_USER;
  assign shifting = state == SH_IR || state == SH_DR;
`ifdef JTAG_IDCODE_EN
  logic [31:0] id;
  assign dr_src = ir == OP_IDCODE ? id[0] : bus.ext_sel ? bus.ext_tdo : bypass;
`else
  assign dr_src = bus.ext_sel ? bus.ext_tdo : bypass;
`endif
  assign tdo_src    = state == SH_IR ? ir_shift[0] : dr_src;
  assign bus.ir_out = ir;
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state          <= TLR;
      ir             <= IR_RST;
      ir_shift       <= IR_CAP;
      bypass         <= 1'b0;
`ifdef JTAG_IDCODE_EN
      id             <= IDCODE_VALUE;
`endif
      bus.tlr        <= 1'b1;
      bus.ext_sel    <= 1'b0;
      bus.capture_dr <= 1'b0;
      bus.shift_dr   <= 1'b0;
      bus.update_dr  <= 1'b0;
    end else begin
      state          <= nxt;
      ir             <= ir_nxt;
      ir_shift       <= state == CAP_IR ? IR_CAP : state == SH_IR ? {bus.tdi, ir_shift[IR_WIDTH-1:1]} : ir_shift;
      bypass         <= state == CAP_DR ? 1'b0 : state == SH_DR ? bus.tdi : bypass;
`ifdef JTAG_IDCODE_EN
      id             <= state == CAP_DR ? IDCODE_VALUE : state == SH_DR ? {bus.tdi, id[31:1]} : id;
`endif
      bus.tlr        <= nxt == TLR;
      bus.ext_sel    <= user_nxt;
      bus.capture_dr <= user_nxt && nxt == CAP_DR;
      bus.shift_dr   <= user_nxt && nxt == SH_DR;
      bus.update_dr  <= user_nxt && nxt == UPD_DR;
    end
  end
  // Falling-edge launch gives the receiver a full half period of setup before the next rising edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      bus.tdo    <= 1'b0;
      bus.tdo_en <= 1'b0;
    end else begin
      bus.tdo    <= shifting & tdo_src;
      bus.tdo_en <= shifting;
    end
  end
endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller: directed vector table plus hand sequences for resets, IR/DR scans and TLR recovery.
module tb_jtag_tap_controller;
  logic tck = 1'b0, trst = 1'b1;
  int passed = 0, total = 0, upd_cnt = 0;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'b0001;
`else
  localparam logic [3:0] RST_IR = 4'b1111;
`endif
  typedef struct {
    logic       tms, tdi, ext;
    logic [6:0] fl;
    logic [3:0] ir;
  } vec_t;
  vec_t vec[21];
  jtag_tap_controller_if #(.IR_WIDTH(4)) bus ();
  jtag_tap_controller #(.IR_WIDTH(4), .IDCODE_VALUE(32'h1000_0001)) dut (.tck(tck), .trst(trst), .bus(bus));
  always #5 tck = ~tck;
  always @(posedge bus.update_dr) upd_cnt++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    #1;
    @(negedge tck);
    #1;
  endtask
  task automatic tms_seq(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s[i], 1'b0);
  endtask
  task automatic reset();
    trst = 1'b0;
    #2;
    trst = 1'b1;
  endtask
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] obs);
    tms_seq(16'b0011, 4);
    for (int i = 0; i < 4; i++) begin
      obs[i] = bus.tdo;
      tick(i == 3, v[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask
  task automatic bypass_pat(output logic [3:0] obs);
    logic [3:0] pat;
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      obs[i] = bus.tdo;
      tick(i == 3, pat[i]);
    end
  endtask
  function automatic vec_t mk(input logic t, input logic d, input logic e, input logic [6:0] f, input logic [3:0] i);
    vec_t v;
    v.tms = t; v.tdi = d; v.ext = e; v.fl = f; v.ir = i;
    return v;
  endfunction
  initial begin
    logic [3:0]  obs;
    logic [31:0] idr;
    int          cnt0;
    // flags: {tlr, capture_dr, shift_dr, update_dr, ext_sel, tdo_en, tdo}
    vec[0]  = mk(0, 0, 0, 7'b0000000, RST_IR);
    vec[1]  = mk(1, 0, 0, 7'b0000000, RST_IR);
    vec[2]  = mk(1, 0, 0, 7'b0000000, RST_IR);
    vec[3]  = mk(0, 0, 0, 7'b0000000, RST_IR);
    vec[4]  = mk(0, 0, 0, 7'b0000011, RST_IR);
    vec[5]  = mk(0, 0, 0, 7'b0000010, RST_IR);
    vec[6]  = mk(0, 0, 0, 7'b0000010, RST_IR);
    vec[7]  = mk(0, 0, 0, 7'b0000010, RST_IR);
    vec[8]  = mk(1, 1, 0, 7'b0000000, RST_IR);
    vec[9]  = mk(1, 0, 0, 7'b0000000, RST_IR);
    vec[10] = mk(0, 0, 0, 7'b0000100, 4'b1000);
    vec[11] = mk(1, 0, 0, 7'b0000100, 4'b1000);
    vec[12] = mk(0, 0, 0, 7'b0100100, 4'b1000);
    vec[13] = mk(0, 0, 1, 7'b0010111, 4'b1000);
    vec[14] = mk(0, 0, 0, 7'b0010110, 4'b1000);
    vec[15] = mk(0, 0, 1, 7'b0010111, 4'b1000);
    vec[16] = mk(1, 0, 0, 7'b0000100, 4'b1000);
    vec[17] = mk(0, 0, 0, 7'b0000100, 4'b1000);
    vec[18] = mk(1, 0, 0, 7'b0000100, 4'b1000);
    vec[19] = mk(1, 0, 0, 7'b0001100, 4'b1000);
    vec[20] = mk(0, 0, 0, 7'b0000100, 4'b1000);
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.ext_tdo = 1'b0;
    @(negedge tck);
    #1;
    reset();
    check("rst_tlr", bus.tlr, 1);
    check("rst_ir", bus.ir_out, RST_IR);
    check("rst_tdo", {bus.tdo_en, bus.tdo}, 0);
    check("rst_sel", {bus.ext_sel, bus.capture_dr, bus.shift_dr, bus.update_dr}, 0);
    for (int i = 0; i < 21; i++) begin
      bus.ext_tdo = vec[i].ext;
      tick(vec[i].tms, vec[i].tdi);
      check($sformatf("vec%0d", i),
            {bus.tlr, bus.capture_dr, bus.shift_dr, bus.update_dr, bus.ext_sel, bus.tdo_en, bus.tdo, bus.ir_out},
            {vec[i].fl, vec[i].ir});
    end
    check("user_upd_pulses", upd_cnt, 1);
    bus.ext_tdo = 1'b0;
    reset();
    tick(0, 0);
    ir_scan(4'b1111, obs);
    check("bp_ir_capture", obs, 4'b0001);
    check("bp_ir", bus.ir_out, 4'b1111);
    tms_seq(16'b001, 3);
    bypass_pat(obs);
    check("bp_tdo", obs, 4'b1010);
    check("bp_exit_en", bus.tdo_en, 0);
`ifdef JTAG_IDCODE_EN
    reset();
    tms_seq(16'b0010, 4);
    check("id_en", bus.tdo_en, 1);
    for (int i = 0; i < 32; i++) begin
      idr[i] = bus.tdo;
      tick(i == 31, 1'b0);
    end
    check("idcode", idr, 32'h1000_0001);
`else
    reset();
    tick(0, 0);
    ir_scan(4'b0001, obs);
    check("noid_ir", bus.ir_out, 4'b0001);
    tms_seq(16'b001, 3);
    bypass_pat(obs);
    check("noid_bp_tdo", obs, 4'b1010);
`endif
    reset();
    tick(0, 0);
    check("rti_tlr0", bus.tlr, 0);
    tms_seq(16'h1f, 5);
    check("rti_5ones", bus.tlr, 1);
    reset();
    tick(0, 0);
    tms_seq(16'b0011, 4);
    tms_seq(16'hf, 4);
    check("shir_4ones", bus.tlr, 0);
    tick(1, 0);
    check("shir_5ones", bus.tlr, 1);
    reset();
    tick(0, 0);
    tms_seq(16'b01001, 5);
    check("pausedr_tlr0", bus.tlr, 0);
    tms_seq(16'h1f, 5);
    check("pausedr_5ones", bus.tlr, 1);
    reset();
    tick(0, 0);
    tms_seq(16'b110011, 6);
    tms_seq(16'h1f, 5);
    check("updir_5ones", bus.tlr, 1);
    check("updir_ir", bus.ir_out, RST_IR);
    reset();
    tick(0, 0);
    ir_scan(4'b1000, obs);
    tms_seq(16'b001, 3);
    check("mid_shdr", bus.shift_dr, 1);
    cnt0 = upd_cnt;
    bus.ext_tdo = 1'b1;
    tick(0, 1);
    trst = 1'b0;
    #1;
    check("trst_tlr", bus.tlr, 1);
    check("trst_ir", bus.ir_out, RST_IR);
    check("trst_en", {bus.tdo_en, bus.tdo}, 0);
    check("trst_dr", {bus.ext_sel, bus.shift_dr, bus.update_dr}, 0);
    #1;
    trst = 1'b1;
    tick(0, 0);
    check("post_trst_rti", {bus.tlr, bus.ir_out}, {1'b0, RST_IR});
    check("trst_no_upd", upd_cnt, cnt0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
